// File: rtl/wb_write_port.sv
// Write-back port: in-order buffer of retiring results that drives the register file write port,
// with a youngest-first bypass lookup. Define WB_RETIRE_CNT_EN to add the retire_count output.
module wb_write_port #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_reg_write,
    input  logic          in_mem_to_reg,
    input  logic [AW-1:0] in_rd,
    input  logic [DW-1:0] in_read_data,
    input  logic [DW-1:0] in_alu_result,
    input  logic          wp_ready,
    output logic          reg_write,
    output logic [AW-1:0] rd,
    output logic [DW-1:0] write_data,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    output logic          hit_a,
    output logic          hit_b,
    output logic [DW-1:0] fwd_a,
    output logic [DW-1:0] fwd_b
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]   retire_count
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] rd_q   [DEPTH];
    logic [AW-1:0] rd_d   [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    logic not_empty;
    logic accept;
    logic push;
    logic pop;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != CW'(DEPTH));
    assign accept    = in_valid && in_ready;
    // Writes to $0 and non-writing instructions are consumed without occupying a slot.
    assign push      = accept && in_reg_write && (in_rd != '0);
    assign pop       = not_empty && wp_ready;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rd_d[i]   = rd_q[i];
            data_d[i] = data_q[i];
        end
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            rd_d[wptr_q]   = in_rd;
            data_d[wptr_q] = in_mem_to_reg ? in_read_data : in_alu_result;
            wptr_d         = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= rd_d[i];
                data_q[i] <= data_d[i];
            end
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Head entry is gated so a drained buffer presents zeros rather than stale contents.
    always_comb begin
        reg_write  = not_empty;
        rd         = not_empty ? rd_q[rptr_q] : '0;
        write_data = not_empty ? data_q[rptr_q] : '0;
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx   = '0;
        hit_a = 1'b0;
        hit_b = 1'b0;
        fwd_a = '0;
        fwd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((rs != '0) && (rd_q[idx] == rs)) begin
                    hit_a = 1'b1;
                    fwd_a = data_q[idx];
                end
                if ((rt != '0) && (rd_q[idx] == rt)) begin
                    hit_b = 1'b1;
                    fwd_b = data_q[idx];
                end
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (pop) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_count = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_write_port.sv
// Scoreboard bench for wb_write_port: expected writes are queued at accept time and
// a negedge monitor checks every completed register-file write against the queue.
module tb_wb_write_port;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_reg_write;
    logic          in_mem_to_reg;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_read_data;
    logic [DW-1:0] in_alu_result;
    logic          wp_ready;
    logic          reg_write;
    logic [AW-1:0] rd;
    logic [DW-1:0] write_data;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          hit_a;
    logic          hit_b;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0]   retire_count;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    wb_write_port #(.DEPTH(2), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg_write  (in_reg_write),
        .in_mem_to_reg (in_mem_to_reg),
        .in_rd         (in_rd),
        .in_read_data  (in_read_data),
        .in_alu_result (in_alu_result),
        .wp_ready      (wp_ready),
        .reg_write     (reg_write),
        .rd            (rd),
        .write_data    (write_data),
        .rs            (rs),
        .rt            (rt),
        .hit_a         (hit_a),
        .hit_b         (hit_b),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_count  (retire_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a write completes at the next posedge when reg_write && wp_ready.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && reg_write === 1'b1 && wp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(rd), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("sb_rd", 32'(rd), 32'(e.rd));
                chk("sb_data", write_data, e.data);
            end
        end
    end

    // Present one instruction and hold it until accepted (bounded); returns at posedge+1.
    task automatic accept(input logic [AW-1:0] d, input logic regw, input logic mtr,
                          input logic [DW-1:0] rdata, input logic [DW-1:0] alu);
        logic rdy;
        in_valid      = 1'b1;
        in_reg_write  = regw;
        in_mem_to_reg = mtr;
        in_rd         = d;
        in_read_data  = rdata;
        in_alu_result = alu;
        rdy           = 1'b0;
        for (int n = 0; n < 20 && !rdy; n++) begin
            #0;
            rdy = in_ready;
            @(posedge clk);
            if (rdy && regw && d != '0) begin
                exp_q.push_back({d, mtr ? rdata : alu});
            end
            #1;
        end
        if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || reg_write) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drained", 32'(exp_q.size()), 32'd0);
        chk("drained_regwrite", 32'(reg_write), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0;
        in_rd = '0; in_read_data = '0; in_alu_result = '0; wp_ready = 1'b0;
        rs = '0; rt = '0;
        #12;
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_hit", 32'({hit_a, hit_b}), 32'd0);
`ifdef WB_RETIRE_CNT_EN
        chk("rst_retire_count", retire_count, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write with immediate completion.
        wp_ready = 1'b1;
        accept(5'd2, 1'b1, 1'b0, 32'h0, 32'd5);
        chk("t1_reg_write", 32'(reg_write), 32'd1);
        chk("t1_rd", 32'(rd), 32'd2);
        chk("t1_data", write_data, 32'd5);
        @(posedge clk); #1;
        chk("t1_done", 32'(reg_write), 32'd0);

        // Stall: fill, hold head, then release in order.
        wp_ready = 1'b0;
        accept(5'd1, 1'b1, 1'b1, 32'h0023_00AA, 32'h1065_4321);
        accept(5'd3, 1'b1, 1'b0, 32'h0, 32'h0010_0022);
        chk("t2_full", 32'(in_ready), 32'd0);
        chk("t2_rd", 32'(rd), 32'd1);
        chk("t2_data", write_data, 32'h0023_00AA);
        repeat (2) @(posedge clk);
        #1;
        chk("t2_hold_rd", 32'(rd), 32'd1);
        chk("t2_hold_data", write_data, 32'h0023_00AA);
        wp_ready = 1'b1;
        drain();

        // Bypass: youngest of two same-rd entries wins.
        wp_ready = 1'b0;
        accept(5'd4, 1'b1, 1'b0, 32'h0, 32'hAA);
        accept(5'd4, 1'b1, 1'b0, 32'h0, 32'hBB);
        rs = 5'd4; rt = 5'd5; #1;
        chk("t3_hit_a", 32'(hit_a), 32'd1);
        chk("t3_fwd_a", fwd_a, 32'hBB);
        chk("t3_hit_b", 32'(hit_b), 32'd0);
        chk("t3_fwd_b", fwd_b, 32'd0);
        rs = 5'd0; rt = 5'd4; #1;
        chk("t3_rs0_hit", 32'(hit_a), 32'd0);
        chk("t3_fwd_b2", fwd_b, 32'hBB);
        wp_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_popping_hit", 32'(hit_b), 32'd1);
        chk("t3_popping_fwd", fwd_b, 32'hBB);
        drain();
        chk("t3_empty_hit", 32'(hit_b), 32'd0);
        rs = '0; rt = '0;

        // Dropped accepts.
        accept(5'd0, 1'b1, 1'b0, 32'h0, 32'h77);
        chk("t4_rd0", 32'(reg_write), 32'd0);
        accept(5'd7, 1'b0, 1'b0, 32'h0, 32'h88);
        chk("t4_noreg", 32'(reg_write), 32'd0);

        // Full buffer with simultaneous pop/push.
        wp_ready = 1'b0;
        accept(5'd10, 1'b1, 1'b0, 32'h0, 32'h1);
        accept(5'd11, 1'b1, 1'b0, 32'h0, 32'h2);
        wp_ready = 1'b1;
        in_valid = 1'b1; in_reg_write = 1'b1; in_mem_to_reg = 1'b0;
        in_rd = 5'd12; in_alu_result = 32'h3; #1;
        chk("t5_full_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("t5_ready_back", 32'(in_ready), 32'd1);
        accept(5'd12, 1'b1, 1'b0, 32'h0, 32'h3);
        accept(5'd13, 1'b1, 1'b0, 32'h0, 32'h4);
        accept(5'd14, 1'b1, 1'b1, 32'h5, 32'h0);
        drain();

        // Asynchronous reset with pending writes.
        wp_ready = 1'b0;
        accept(5'd8, 1'b1, 1'b0, 32'h0, 32'h11);
        accept(5'd9, 1'b1, 1'b0, 32'h0, 32'h22);
        rs = 5'd8;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_reg_write", 32'(reg_write), 32'd0);
        chk("t6_rd", 32'(rd), 32'd0);
        chk("t6_data", write_data, 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_hit_a", 32'(hit_a), 32'd0);
        exp_q.delete();
        #3 rst_n = 1'b1;
        rs = '0;
        @(posedge clk); #1;
`ifdef WB_RETIRE_CNT_EN
        chk("t6_retire_rst", retire_count, 32'd0);
        wp_ready = 1'b1;
        accept(5'd1, 1'b1, 1'b0, 32'h0, 32'h1);
        accept(5'd0, 1'b1, 1'b0, 32'h0, 32'h9);
        accept(5'd2, 1'b1, 1'b0, 32'h0, 32'h2);
        accept(5'd3, 1'b1, 1'b0, 32'h0, 32'h3);
        drain();
        chk("t6_retire_3", retire_count, 32'd3);
`endif
        chk("t6_idle", 32'(reg_write), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_write_port.md
Name: wb_write_port

Overview:
- Write-back side of the register file: takes retiring results from the MEM/WB boundary and drives the register file write port (reg_write, rd, write_data).
- Holds up to DEPTH results in a small in-order buffer so that a busy write port stalls MEM instead of dropping results.
- Provides a youngest-first bypass lookup on rs/rt so the ID stage can read values still pending write-back.

Parameters:
- DEPTH, 2, number of buffer entries (power of two, 2..8).
- AW, 5, register index width.
- DW, 32, data width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  MEM presents a retiring instruction.
- in_ready  out  1  buffer can accept; equals !full (registered state only, no path from wp_ready).
- in_reg_write  in  1  instruction writes a register.
- in_mem_to_reg  in  1  1 selects in_read_data, 0 selects in_alu_result.
- in_rd  in  AW  destination register.
- in_read_data  in  DW  load data.
- in_alu_result  in  DW  ALU result.
- wp_ready  in  1  register file accepts the write this cycle.
- reg_write  out  1  write request to register file.
- rd  out  AW  write address.
- write_data  out  DW  write data.
- rs, rt  in  AW each  bypass lookup addresses.
- hit_a, hit_b  out  1 each  rs/rt match a pending entry.
- fwd_a, fwd_b  out  DW each  youngest matching pending data.

Behaviour:
- Reset (async, rst_n=0): buffer empty; reg_write=0, rd=0, write_data=0, hit_a=hit_b=0, fwd_a=fwd_b=0, in_ready=1. Reset may assert mid-operation; pending writes are discarded with no partial write.
- Accept: at a rising edge with in_valid && in_ready.
  - Data is muxed at capture (in_mem_to_reg ? in_read_data : in_alu_result) and stored with in_rd.
  - An accept with in_reg_write=0 or in_rd=0 is consumed but not stored. Register $0 is never written.
- Output: reg_write=1 whenever the buffer is non-empty; rd and write_data come from the head entry flops.
  - Latency: an entry accepted at edge N is on the port from just after edge N.
- Complete: reg_write && wp_ready at an edge pops the head. With wp_ready=0, the head holds stable with no change to rd or write_data.
- Simultaneous push and pop: both take effect at the same edge, so occupancy is unchanged.
  - When full, in_ready=0 even if wp_ready=1; a pop frees the slot for the next cycle.
- Order: strictly FIFO. Pointers wrap modulo DEPTH, and an occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
- Bypass (combinational over stored entries only):
  - hit_a=1 if any valid entry has rd==rs and rs!=0. fwd_a is the youngest such entry's data, else 0. The same rules apply to rt, hit_b and fwd_b.
  - The entry being popped this cycle still counts as pending.
  - Same-cycle in_* inputs are not bypassed.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_count (32 bits). It is reset to 0 and increments by 1 at each completed write (reg_write && wp_ready).
  - It wraps from 0xFFFFFFFF to 0.
  - Dropped accepts (no write, or rd=0) do not count.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then accept in_rd=2, in_mem_to_reg=0, in_alu_result=5 with wp_ready=1 -> next cycle reg_write=1, rd=2, write_data=5; following cycle reg_write=0.
- wp_ready=0 while accepting in_rd=1 (alu 'h10654321, read_data 'h002300AA, in_mem_to_reg=1) and then in_rd=3 ('h00100022) -> in_ready=0 after 2 accepts; port holds rd=1/'h002300AA. Raise wp_ready -> writes emitted in order: rd=1 then rd=3.
- Two pending writes to rd=4 (values 'hAA then 'hBB) with wp_ready=0, rs=4, rt=5 -> hit_a=1, fwd_a='hBB, hit_b=0, fwd_b=0.
- Accept with in_rd=0 or in_reg_write=0 -> no store, reg_write stays 0; rs=0 never hits.
- Full buffer with wp_ready=1 and in_valid=1 -> one pop per cycle; in_ready returns to 1 the cycle after the first pop; no data lost or reordered.
- rst_n pulsed low asynchronously between edges with 2 pending -> outputs 0 immediately, in_ready=1. With WB_RETIRE_CNT_EN, retire_count=0 after reset and equals the number of completed writes (3 after three writes).
